// File: rtl/buffer_double_lane.sv
// One lane of the double-buffered accumulator: two OWID-bit banks, one accumulates
// while the other is presented on the output.
module buffer_double_lane #(
  parameter int unsigned IWID = 1,
  parameter int unsigned OWID = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_sel,
  input  logic            clear,
  input  logic [IWID-1:0] inc,
  output logic [OWID-1:0] lane_out
);

  logic [OWID-1:0] bank_a_q, bank_a_d;
  logic [OWID-1:0] bank_b_q, bank_b_d;
  logic [OWID-1:0] sum;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    bank_a_d = bank_a_q;
    bank_b_d = bank_b_q;
    // Overflow wraps naturally at OWID bits; clear takes priority over the add.
    sum      = (acc_sel ? bank_b_q : bank_a_q) + OWID'(inc);
    if (!acc_sel) begin
      bank_a_d = clear ? '0 : sum;
    end else begin
      bank_b_d = clear ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      bank_a_q <= '0;
      bank_b_q <= '0;
    end else begin
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
    end
  end

  // The idle bank is the one visible; a select change shows up on the output at once.
  assign lane_out = acc_sel ? bank_a_q : bank_b_q;

endmodule

// File: rtl/buffer_double_array.sv
// Double-buffered per-lane accumulator array: IDIM identical lanes, each with an
// accumulating bank and a readable bank chosen by iAccSel.
module buffer_double_array #(
  parameter int unsigned IDIM = 4,
  parameter int unsigned IWID = 1,
  parameter int unsigned OWID = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iAccSel,
  input  logic            iClear,
  input  logic [IWID-1:0] iData [IDIM],
  output logic [OWID-1:0] oData [IDIM]
);

  for (genvar g = 0; g < IDIM; g++) begin : g_lane
    buffer_double_lane #(
      .IWID (IWID),
      .OWID (OWID)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .acc_sel  (iAccSel),
      .clear    (iClear),
      .inc      (iData[g]),
      .lane_out (oData[g])
    );
  end

endmodule

// File: tb/tb_buffer_double_array.sv
// Bench for buffer_double_array: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a two-bank array model.
module tb_buffer_double_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       sel0, clr0;
  logic [0:0] d0 [4];
  logic [31:0] q0 [4];

  // Narrow instance for wrap and multi-bit lane checks.
  logic       sel1, clr1;
  logic [1:0] d1 [4];
  logic [3:0] q1 [4];

  buffer_double_array dut0 (
    .clk(clk), .rst(rst), .iAccSel(sel0), .iClear(clr0), .iData(d0), .oData(q0)
  );

  buffer_double_array #(.IDIM(4), .IWID(2), .OWID(4)) dut1 (
    .clk(clk), .rst(rst), .iAccSel(sel1), .iClear(clr1), .iData(d1), .oData(q1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bank[b][lane], b=0 is A, b=1 is B; arithmetic wraps at the declared width.
  logic [31:0] m0 [2][4];
  logic [3:0]  m1 [2][4];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m0[0][i] = '0; m0[1][i] = '0;
        m1[0][i] = '0; m1[1][i] = '0;
      end else begin
        m0[sel0][i] = clr0 ? 32'd0 : m0[sel0][i] + 32'(d0[i]);
        m1[sel1][i] = clr1 ? 4'd0  : m1[sel1][i] + 4'(d1[i]);
      end
    end
  end

  // Compare process: the visible bank is always the one not selected.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model0 lane%0d", i), q0[i], m0[!sel0][i]);
      check($sformatf("model1 lane%0d", i), {28'd0, q1[i]}, {28'd0, m1[!sel1][i]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d0(input logic v);
    for (int i = 0; i < 4; i++) d0[i] = v;
  endtask

  task automatic set_d1(input logic [1:0] v);
    for (int i = 0; i < 4; i++) d1[i] = v;
  endtask

  task automatic check_q0(input string name, input int unsigned exp);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("%s lane%0d", name, i), q0[i], exp);
  endtask

  initial begin
    logic [3:0] lane_exp [4];
    sel0 = 1'b0; clr0 = 1'b0; set_d0(1'b1);
    sel1 = 1'b0; clr1 = 1'b0; set_d1(2'd0);

    // Reset held with nonzero input: both banks must read zero.
    repeat (3) step();
    check_q0("reset bankB", 0);
    sel0 = 1'b1;
    check_q0("reset bankA", 0);
    sel0 = 1'b0; set_d0(1'b0);
    rst = 1'b0;
    step();
    check_q0("post-reset bankB", 0);
    sel0 = 1'b1;
    check_q0("post-reset bankA", 0);

    // Accumulate 20 ones into A, then view A.
    sel0 = 1'b0; set_d0(1'b1);
    repeat (20) step();
    sel0 = 1'b1; set_d0(1'b0);
    check_q0("accum A=20", 20);

    // 10 ones into B must not disturb A; then view B.
    set_d0(1'b1);
    repeat (10) step();
    check_q0("isolation A", 20);
    sel0 = 1'b0; set_d0(1'b0);
    check_q0("bank B=10", 10);

    // Clear A for one cycle, then add 5; B untouched.
    clr0 = 1'b1;
    step();
    clr0 = 1'b0; set_d0(1'b1);
    repeat (5) step();
    set_d0(1'b0); sel0 = 1'b1;
    check_q0("clear A=5", 5);
    sel0 = 1'b0;
    check_q0("clear keeps B", 10);

    // Wrap: 17 ones into a 4-bit bank reads 1.
    sel1 = 1'b0; set_d1(2'd1);
    repeat (17) step();
    sel1 = 1'b1; set_d1(2'd0);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("wrap lane%0d", i), {28'd0, q1[i]}, 32'd1);

    // Lane independence: per-lane increments {3,2,1,0} for 4 cycles into B.
    d1 = '{2'd3, 2'd2, 2'd1, 2'd0};
    repeat (4) step();
    sel1 = 1'b0; set_d1(2'd0);
    lane_exp = '{4'd12, 4'd8, 4'd4, 4'd0};
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("lanes lane%0d", i), {28'd0, q1[i]}, {28'd0, lane_exp[i]});

    // Randomized traffic with occasional clears and mid-run resets.
    for (int n = 0; n < 400; n++) begin
      step();
      sel0 = 1'($urandom_range(0, 1));
      clr0 = ($urandom_range(0, 7) == 0);
      sel1 = 1'($urandom_range(0, 1));
      clr1 = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 4; i++) begin
        d0[i] = 1'($urandom_range(0, 1));
        d1[i] = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
